fetch_ctrl: RTL and testbench

//  Pipeline control unit that sequences the fetch stage. Generates the PC enable,

---
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage pipeline control: boot hold, branch redirect, load-use bubbles and
// terminal halt, with saturating stall/flush event counters.
module fetch_ctrl #(
   parameter int unsigned BOOT_CYC   = 4,
   parameter int unsigned LD_BUBBLES = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_br_taken,
   input  logic [31:0]      i_br_target,
   input  logic             i_ld_use,
   input  logic             i_halt,
   output logic             o_pc_en,
   output logic             o_pc_sel,
   output logic [31:0]      o_pc_br,
   output logic             o_stall_ifid,
   output logic             o_flush_ifid,
   output logic             o_flush_idex,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_LDSTALL,
      ST_HALT
   } state_t;

   localparam logic [2:0] BOOT_INIT = 3'(BOOT_CYC - 1);
   localparam logic [2:0] LD_INIT   = 3'(LD_BUBBLES - 2);

   state_t           r_state;
   state_t           w_nextState;
   logic [2:0]       r_cnt;
   logic [2:0]       w_nextCnt;
   logic             w_incStall;
   logic             w_incFlush;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_BOOT;
         r_cnt   <= BOOT_INIT;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // Halt outranks a same-cycle branch so the halting instruction never redirects.
   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      w_incStall   = 1'b0;
      w_incFlush   = 1'b0;
      o_pc_en      = 1'b0;
      o_pc_sel     = 1'b0;
      o_pc_br      = 32'h0;
      o_stall_ifid = 1'b0;
      o_flush_ifid = 1'b0;
      o_flush_idex = 1'b0;
      o_halted     = 1'b0;
      case (r_state)
         ST_BOOT: begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
            if (r_cnt == 3'd0) begin
               w_nextState = ST_RUN;
            end else begin
               w_nextCnt = r_cnt - 3'd1;
            end
         end
         ST_RUN: begin
            if (i_halt) begin
               o_flush_ifid = 1'b1;
               o_flush_idex = 1'b1;
               w_nextState  = ST_HALT;
            end else if (i_br_taken) begin
               o_pc_en      = 1'b1;
               o_pc_sel     = 1'b1;
               o_pc_br      = i_br_target;
               o_flush_ifid = 1'b1;
               o_flush_idex = 1'b1;
               w_incFlush   = 1'b1;
            end else if (i_ld_use) begin
               o_stall_ifid = 1'b1;
               o_flush_idex = 1'b1;
               w_incStall   = 1'b1;
               if (LD_BUBBLES > 1) begin
                  w_nextCnt   = LD_INIT;
                  w_nextState = ST_LDSTALL;
               end
            end else begin
               o_pc_en = 1'b1;
            end
         end
         ST_LDSTALL: begin
            if (i_halt) begin
               o_flush_ifid = 1'b1;
               o_flush_idex = 1'b1;
               w_nextState  = ST_HALT;
            end else if (i_br_taken) begin
               o_pc_en      = 1'b1;
               o_pc_sel     = 1'b1;
               o_pc_br      = i_br_target;
               o_flush_ifid = 1'b1;
               o_flush_idex = 1'b1;
               w_incFlush   = 1'b1;
               w_nextState  = ST_RUN;
            end else begin
               o_stall_ifid = 1'b1;
               o_flush_idex = 1'b1;
               w_incStall   = 1'b1;
               if (r_cnt == 3'd0) begin
                  w_nextState = ST_RUN;
               end else begin
                  w_nextCnt = r_cnt - 3'd1;
               end
            end
         end
         ST_HALT: begin
            o_halted     = 1'b1;
            o_flush_ifid = 1'b1;
         end
         default: begin
            w_nextState = ST_BOOT;
         end
      endcase
   end

   // Event counters stick at all-ones instead of wrapping.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (w_incStall && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
         if (w_incFlush && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + CNT_W'(1);
         end
      end
   end

   assign o_stall_cnt = r_stallCnt;
   assign o_flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: instance A (LD_BUBBLES=3) covers boot, redirect,
// multi-bubble stall and halt; instance B (LD_BUBBLES=1, CNT_W=2) covers single bubbles and saturation.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        brA, ldA, haltA;
   logic [31:0] tgtA;
   logic        pcEnA, pcSelA, stallA, flIfA, flIdA, haltedA;
   logic [31:0] pcBrA;
   logic [15:0] stallCntA, flushCntA;

   logic        brB, ldB, haltB;
   logic [31:0] tgtB;
   logic        pcEnB, pcSelB, stallB, flIfB, flIdB, haltedB;
   logic [31:0] pcBrB;
   logic [1:0]  stallCntB, flushCntB;

   logic [31:0] pcA;

   int nChecks = 0;
   int nBad    = 0;

   fetch_ctrl #(.BOOT_CYC(4), .LD_BUBBLES(3), .CNT_W(16)) dutA (
      .i_clk(clk), .i_rst(rst), .i_br_taken(brA), .i_br_target(tgtA),
      .i_ld_use(ldA), .i_halt(haltA), .o_pc_en(pcEnA), .o_pc_sel(pcSelA),
      .o_pc_br(pcBrA), .o_stall_ifid(stallA), .o_flush_ifid(flIfA),
      .o_flush_idex(flIdA), .o_halted(haltedA), .o_stall_cnt(stallCntA),
      .o_flush_cnt(flushCntA)
   );

   fetch_ctrl #(.BOOT_CYC(4), .LD_BUBBLES(1), .CNT_W(2)) dutB (
      .i_clk(clk), .i_rst(rst), .i_br_taken(brB), .i_br_target(tgtB),
      .i_ld_use(ldB), .i_halt(haltB), .o_pc_en(pcEnB), .o_pc_sel(pcSelB),
      .o_pc_br(pcBrB), .o_stall_ifid(stallB), .o_flush_ifid(flIfB),
      .o_flush_idex(flIdB), .o_halted(haltedB), .o_stall_cnt(stallCntB),
      .o_flush_cnt(flushCntB)
   );

   // Stand-in fetch PC register steered by instance A's controls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pcA <= 32'h0;
      else if (pcEnA) pcA <= pcSelA ? pcBrA : pcA + 32'd4;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic ld, input logic hlt);
      brA   = br;
      tgtA  = tgt;
      ldA   = ld;
      haltA = hlt;
      #1;
   endtask

   task automatic nextCycle;
      @(negedge clk);
      #1;
   endtask

   logic sawPcEn;
   logic [31:0] pcFrozen;

   initial begin
      rst = 1'b0;
      brA = 0; tgtA = 0; ldA = 0; haltA = 0;
      brB = 0; tgtB = 0; ldB = 0; haltB = 0;
      repeat (4) @(negedge clk);
      #1;
      checkOutput("rst_pc_en", pcEnA, 0);
      checkOutput("rst_flush_ifid", flIfA, 1);
      checkOutput("rst_flush_idex", flIdA, 1);
      checkOutput("rst_halted", haltedA, 0);
      checkOutput("rst_pc_br", pcBrA, 0);
      checkOutput("rst_stall_cnt", stallCntA, 0);

      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("boot_pc_en", pcEnA, 0);
         checkOutput("boot_flush_ifid", flIfA, 1);
         nextCycle();
      end
      checkOutput("run_pc_en", pcEnA, 1);
      checkOutput("pc_0", pcA, 32'h0);
      nextCycle();
      checkOutput("pc_4", pcA, 32'h4);
      nextCycle();
      checkOutput("pc_8", pcA, 32'h8);

      applyStimulus(1, 32'h4, 0, 0);
      checkOutput("br_pc_sel", pcSelA, 1);
      checkOutput("br_pc_br", pcBrA, 32'h4);
      checkOutput("br_flush_ifid", flIfA, 1);
      checkOutput("br_flush_idex", flIdA, 1);
      checkOutput("br_pc_en", pcEnA, 1);
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("br_pc_after", pcA, 32'h4);
      checkOutput("br_flush_cnt", flushCntA, 1);
      checkOutput("idle_pc_sel", pcSelA, 0);
      checkOutput("idle_pc_br", pcBrA, 0);

      applyStimulus(0, 32'h0, 1, 0);
      checkOutput("ld_pc_en", pcEnA, 0);
      checkOutput("ld_stall", stallA, 1);
      checkOutput("ld_flush_idex", flIdA, 1);
      checkOutput("ld_flush_ifid", flIfA, 0);
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("bub2_pc_held", pcA, 32'h4);
      checkOutput("bub2_stall", stallA, 1);
      checkOutput("bub2_pc_en", pcEnA, 0);
      checkOutput("bub2_stall_cnt", stallCntA, 1);
      nextCycle();
      checkOutput("bub3_stall_cnt", stallCntA, 2);
      applyStimulus(1, 32'h40, 0, 0);
      checkOutput("abort_pc_sel", pcSelA, 1);
      checkOutput("abort_pc_br", pcBrA, 32'h40);
      checkOutput("abort_stall", stallA, 0);
      checkOutput("abort_pc_en", pcEnA, 1);
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("abort_pc", pcA, 32'h40);
      checkOutput("abort_stall_cnt", stallCntA, 2);
      checkOutput("abort_flush_cnt", flushCntA, 2);
      checkOutput("abort_run", pcEnA, 1);

      applyStimulus(0, 32'h0, 1, 0);
      nextCycle();
      applyStimulus(0, 32'h0, 1, 0);
      checkOutput("ldst_ignore_ld", stallA, 1);
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("ldst_last_bubble", pcEnA, 0);
      nextCycle();
      checkOutput("ldst_done_pc_en", pcEnA, 1);
      checkOutput("ldst_done_pc", pcA, 32'h40);
      checkOutput("ldst_stall_cnt", stallCntA, 5);

      applyStimulus(1, 32'h80, 0, 1);
      checkOutput("halt_pc_en", pcEnA, 0);
      checkOutput("halt_pc_sel", pcSelA, 0);
      checkOutput("halt_pc_br", pcBrA, 0);
      checkOutput("halt_flush_ifid", flIfA, 1);
      checkOutput("halt_flush_idex", flIdA, 1);
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("halted", haltedA, 1);
      checkOutput("halted_flush_ifid", flIfA, 1);
      checkOutput("halted_flush_idex", flIdA, 0);
      pcFrozen = pcA;
      sawPcEn  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (pcEnA) sawPcEn = 1'b1;
         nextCycle();
      end
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("halt_no_pc_en", 32'(sawPcEn), 0);
      checkOutput("halt_pc_frozen", pcA, 32'h40);
      checkOutput("halt_still", haltedA, 1);
      checkOutput("halt_flush_cnt", flushCntA, 2);

      rst = 1'b0;
      #1;
      checkOutput("rerst_halted", haltedA, 0);
      checkOutput("rerst_stall_cnt", stallCntA, 0);
      checkOutput("rerst_flush_cnt", flushCntA, 0);
      checkOutput("rerst_pc_en", pcEnA, 0);
      nextCycle();
      rst = 1'b1;
      repeat (4) nextCycle();
      checkOutput("reboot_pc_en_a", pcEnA, 1);
      checkOutput("reboot_pc_en_b", pcEnB, 1);

      for (int n = 1; n <= 5; n++) begin
         ldB = 1'b1;
         #1;
         checkOutput("b_ld_pc_en", pcEnB, 0);
         checkOutput("b_ld_stall", stallB, 1);
         checkOutput("b_ld_flush_idex", flIdB, 1);
         nextCycle();
         ldB = 1'b0;
         #1;
         checkOutput("b_after_pc_en", pcEnB, 1);
         checkOutput("b_after_stall", stallB, 0);
         checkOutput("b_stall_cnt", stallCntB, (n > 3) ? 3 : n);
         nextCycle();
      end

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
